filter_aud_in_tx: RTL and testbench

//  Transmit end of the filter audio-input handshake: buffers stereo samples {L[31:16],R[15:0]}

---
 rtl/filter_aud_in_tx.sv | 129 ++++++++++++
 tb/tb_filter_aud_in_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/filter_aud_in_tx.sv
// Transmit side of the filter audio-input handshake.
// A small jitter FIFO buffers stereo samples from the audio source. Nothing
// is offered to the filter until PREFILL samples are queued (PRIME). Samples
// then stream out over rts/rtr (STREAM) until the FIFO runs dry. Dropped
// pushes and dry-outs are recorded in sticky flags.
module filter_aud_in_tx #(
    parameter int WIDTH   = 32,
    parameter int PTR     = 3,
    parameter int PREFILL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_wr,
    input  logic [WIDTH-1:0] src_data,
    output logic             src_full,
    output logic             filter_aud_in_rts,
    input  logic             filter_aud_in_rtr,
    output logic [WIDTH-1:0] filter_aud_in,
    input  logic             mute,
    output logic [PTR:0]     fifo_count,
    output logic             ovf_sticky,
    output logic             unf_sticky,
    input  logic             flag_clr
);

    localparam int DEPTH = 1 << PTR;
    localparam logic [PTR:0] FULL_CNT    = {1'b1, {PTR{1'b0}}};
    localparam logic [PTR:0] PREFILL_CNT = (PTR + 1)'(PREFILL);

    typedef enum logic [1:0] {
        PRIME  = 2'b01,
        STREAM = 2'b10
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR-1:0]   rd_ptr;
    logic [PTR-1:0]   wr_ptr;
    logic [PTR:0]     count_next;
    logic             xfc;
    logic             push;
    logic             ovf_set;
    logic             unf_set;

    // rts comes straight from the state register; STREAM always holds data,
    // so there is no path from rtr back into rts.
    assign filter_aud_in_rts = (state == STREAM);
    assign xfc               = filter_aud_in_rts & filter_aud_in_rtr;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push    = src_wr & ((fifo_count != FULL_CNT) | xfc);
    assign ovf_set = src_wr & ~push;

    // Output is zero while muted or while nothing is being offered, so stale
    // memory contents never show after reset.
    assign filter_aud_in = (mute | ~filter_aud_in_rts) ? '0 : mem[rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = fifo_count;
        if (push && !xfc) begin
            count_next = fifo_count + 1'b1;
        end else if (!push && xfc) begin
            count_next = fifo_count - 1'b1;
        end
    end

    // Next-state: prime until PREFILL queued, stream until the last sample leaves.
    always_comb begin
        state_next = state;
        unf_set    = 1'b0;
        case (state)
            PRIME: begin
                if (fifo_count >= PREFILL_CNT) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (count_next == '0) begin
                    state_next = PRIME;
                    unf_set    = 1'b1;
                end
            end
            default: state_next = PRIME;
        endcase
    end

    // Sample storage; written only on accepted pushes, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= src_data;
        end
    end

    // Control registers: state, pointers, occupancy and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PRIME;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            src_full   <= 1'b0;
            ovf_sticky <= 1'b0;
            unf_sticky <= 1'b0;
        end else begin
            state      <= state_next;
            fifo_count <= count_next;
            src_full   <= (count_next == FULL_CNT);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (xfc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (ovf_set) begin
                ovf_sticky <= 1'b1;
            end else if (flag_clr) begin
                ovf_sticky <= 1'b0;
            end
            if (unf_set) begin
                unf_sticky <= 1'b1;
            end else if (flag_clr) begin
                unf_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_filter_aud_in_tx.sv
// Randomized bench for filter_aud_in_tx against a queue-based reference model.
module tb_filter_aud_in_tx;

    localparam int PREFILL = 4;
    localparam int DEPTH   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        src_wr = 1'b0;
    logic [31:0] src_data = '0;
    logic        src_full;
    logic        rts;
    logic        rtr = 1'b0;
    logic [31:0] dout;
    logic        mute = 1'b0;
    logic [3:0]  fifo_count;
    logic        ovf_sticky;
    logic        unf_sticky;
    logic        flag_clr = 1'b0;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [31:0] q[$];
    bit          strm;
    bit          m_ovf;
    bit          m_unf;
    int          pops;
    logic [31:0] nxt = 32'h1111_2222;

    filter_aud_in_tx #(.WIDTH(32), .PTR(3), .PREFILL(PREFILL)) dut (
        .clk               (clk),
        .rst               (rst),
        .src_wr            (src_wr),
        .src_data          (src_data),
        .src_full          (src_full),
        .filter_aud_in_rts (rts),
        .filter_aud_in_rtr (rtr),
        .filter_aud_in     (dout),
        .mute              (mute),
        .fifo_count        (fifo_count),
        .ovf_sticky        (ovf_sticky),
        .unf_sticky        (unf_sticky),
        .flag_clr          (flag_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance the model at the edge.
    task automatic tick();
        int  sz0;
        bit  xfc;
        bit  acc;
        bit  uset;
        @(negedge clk);
        chk("rts", {31'd0, rts}, {31'd0, strm});
        chk("count", {28'd0, fifo_count}, q.size());
        chk("full", {31'd0, src_full}, {31'd0, q.size() == DEPTH});
        chk("ovf", {31'd0, ovf_sticky}, {31'd0, m_ovf});
        chk("unf", {31'd0, unf_sticky}, {31'd0, m_unf});
        if (strm) chk("data", dout, mute ? 32'd0 : q[0]);
        @(posedge clk);
        if (rst) begin
            q.delete();
            strm  = 0;
            m_ovf = 0;
            m_unf = 0;
        end else begin
            sz0  = q.size();
            xfc  = strm && rtr;
            acc  = src_wr && (sz0 < DEPTH || xfc);
            uset = 0;
            if (xfc) begin
                void'(q.pop_front());
                pops++;
            end
            if (acc) q.push_back(src_data);
            if (src_wr && !acc) m_ovf = 1;
            else if (flag_clr) m_ovf = 0;
            if (!strm) begin
                if (sz0 >= PREFILL) strm = 1;
            end else if (q.size() == 0) begin
                strm = 0;
                uset = 1;
            end
            if (uset) m_unf = 1;
            else if (flag_clr) m_unf = 0;
        end
        #1;
    endtask

    task automatic drive(input bit wr, input bit r, input bit clr);
        src_wr   = wr;
        rtr      = r;
        flag_clr = clr;
        if (wr) begin
            src_data = nxt;
            nxt      = nxt + 32'h0001_0001;
        end
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q.size() > 0 || strm); i++) drive(0, 1, 0);
        chk("drained", q.size(), 0);
    endtask

    initial begin
        // power-up reset, model starts clean
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        strm = 0; m_ovf = 0; m_unf = 0; pops = 0;
        rst = 1'b0;

        // prime: 4 pushes with rtr low, rts rises afterwards, then drain in order
        for (int i = 0; i < 4; i++) drive(1, 0, 0);
        repeat (3) drive(0, 0, 0);
        chk("primed_rts", {31'd0, rts}, 32'd1);
        drain();
        chk("unf_after_drain", {31'd0, unf_sticky}, 32'd1);
        drive(0, 0, 1);

        // overflow: 9 pushes into a stalled FIFO, the 9th is dropped
        for (int i = 0; i < 9; i++) drive(1, 0, 0);
        chk("ovf_set", {31'd0, ovf_sticky}, 32'd1);
        chk("full_set", {31'd0, src_full}, 32'd1);
        drive(0, 0, 1);
        chk("ovf_clr", {31'd0, ovf_sticky}, 32'd0);

        // full with simultaneous pop: push accepted, no overflow
        drive(1, 1, 0);
        chk("full_pop_cnt", {28'd0, fifo_count}, 32'd8);
        chk("full_pop_ovf", {31'd0, ovf_sticky}, 32'd0);
        drain();
        drive(0, 0, 1);

        // underflow recovery: 3 pushes keep rts low, the 4th releases it
        for (int i = 0; i < 3; i++) drive(1, 0, 0);
        repeat (3) drive(0, 0, 0);
        chk("under_prefill_rts", {31'd0, rts}, 32'd0);
        drive(1, 0, 0);
        repeat (2) drive(0, 0, 0);
        chk("refill_rts", {31'd0, rts}, 32'd1);
        drain();
        drive(0, 0, 1);

        // mute + wrap: 20 samples, outputs 5..9 muted
        pops = 0;
        begin
            int sent = 0;
            for (int c = 0; c < 400 && (sent < 20 || q.size() > 0); c++) begin
                mute = (pops >= 5 && pops <= 9);
                if (sent < 20 && q.size() < DEPTH && $urandom_range(0, 3) != 0) begin
                    drive(1, $urandom_range(0, 2) != 0, 0);
                    sent++;
                end else begin
                    drive(0, (sent >= 20) || ($urandom_range(0, 2) != 0), 0);
                end
            end
            mute = 1'b0;
            chk("mute_pops", pops, 20);
        end
        drive(0, 0, 1);

        // reset mid-stream with 5 buffered
        for (int i = 0; i < 5; i++) drive(1, 0, 0);
        chk("pre_rst_cnt", {28'd0, fifo_count}, 32'd5);
        rst = 1'b1;
        drive(0, 0, 0);
        drive(0, 0, 0);
        rst = 1'b0;
        chk("rst_cnt", {28'd0, fifo_count}, 32'd0);
        chk("rst_rts", {31'd0, rts}, 32'd0);
        chk("rst_data", dout, 32'd0);
        chk("rst_flags", {30'd0, ovf_sticky, unf_sticky}, 32'd0);

        // random soak
        for (int c = 0; c < 400; c++) begin
            mute = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 1), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
